// File: rtl/vid_gen_pkg.sv
// Shared types and helpers for the AXI4-Stream video frame generator.
package vid_gen_pkg;

   typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} vid_state_t;
   typedef enum logic [1:0] {SOLID, RAMP, BARS, CHECKER} vid_mode_t;

   localparam int NUM_BARS = 8;

   // Counter width for a range of n values; never narrower than one bit.
   function automatic int clog2_min1(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/vid_pattern_calc.sv
// Combinational test-pattern generator: (mode, x, y, solid) -> one pixel.
module vid_pattern_calc
   import vid_gen_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_CH   = 3,
   parameter  int H_ACTIVE = 1920,
   parameter  int V_ACTIVE = 1080,
   parameter  int CHK_LOG2 = 3,
   localparam int X_W      = clog2_min1(H_ACTIVE),
   localparam int Y_W      = clog2_min1(V_ACTIVE),
   localparam int PIX_W    = DATA_W * NUM_CH
)(
   input  logic [1:0]       mode,
   input  logic [X_W-1:0]   x,
   input  logic [Y_W-1:0]   y,
   input  logic [PIX_W-1:0] solid,
   output logic [PIX_W-1:0] pixel
);

   localparam int BAR_W = H_ACTIVE / NUM_BARS;
   localparam int EXT_W = X_W + Y_W + CHK_LOG2 + 1;

   vid_mode_t         mode_e;
   logic [X_W-1:0]    bar_full;
   logic [2:0]        bar;
   logic [DATA_W-1:0] ramp;
   logic              checker_on;

   assign mode_e   = vid_mode_t'(mode);
   assign ramp     = DATA_W'(x);
   assign bar_full = x / X_W'(BAR_W);
   // Leftover pixels when H_ACTIVE is not a multiple of 8 fold into the last bar.
   assign bar      = (bar_full > X_W'(NUM_BARS - 1)) ? 3'(NUM_BARS - 1) : 3'(bar_full);
   assign checker_on = (((EXT_W'(x) >> CHK_LOG2) ^ (EXT_W'(y) >> CHK_LOG2)) & EXT_W'(1)) != '0;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign pixel[gi*DATA_W +: DATA_W] =
         (mode_e == SOLID) ? solid[gi*DATA_W +: DATA_W] :
         (mode_e == RAMP)  ? ramp :
         (mode_e == BARS)  ? {DATA_W{bar[gi % 3]}} :
                             {DATA_W{checker_on}};
   end

endmodule

// File: rtl/axis_vid_frame_gen.sv
// AXI4-Stream video frame source: frame/line sequencing with blanking,
// registered outputs that hold under backpressure, and runtime test patterns.
module axis_vid_frame_gen
   import vid_gen_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 3,
   parameter int H_ACTIVE = 1920,
   parameter int V_ACTIVE = 1080,
   parameter int H_BLANK  = 16,
   parameter int V_BLANK  = 64,
   parameter int CHK_LOG2 = 3
)(
   input  logic                       ACLK,
   input  logic                       ARESETN,
   input  logic                       enable,
   input  logic [1:0]                 mode,
   input  logic [DATA_W*NUM_CH-1:0]   solid_color,
   input  logic                       m_axis_tready,
   output logic                       m_axis_tvalid,
   output logic [DATA_W*NUM_CH-1:0]   m_axis_tdata,
   output logic                       m_axis_tuser,
   output logic                       m_axis_tlast,
   output logic                       busy,
   output logic                       frame_done,
   output logic [15:0]                frame_cnt
);

   localparam int PIX_W  = DATA_W * NUM_CH;
   localparam int X_W    = clog2_min1(H_ACTIVE);
   localparam int Y_W    = clog2_min1(V_ACTIVE);
   localparam int VB_LEN = (V_BLANK < 1) ? 1 : V_BLANK;
   localparam int B_MAX  = (H_BLANK > VB_LEN) ? H_BLANK : VB_LEN;
   localparam int B_W    = clog2_min1(B_MAX);

   logic [1:0]       rst_sync_reg;
   logic             rst_n;

   vid_state_t       state_reg, state_next;
   logic [X_W-1:0]   x_reg, x_next;
   logic [Y_W-1:0]   y_reg, y_next;
   logic [B_W-1:0]   blank_reg, blank_next;
   vid_mode_t        mode_reg, mode_next;
   logic [PIX_W-1:0] solid_reg, solid_next;
   logic             xfer, frame_end;

   logic             tvalid_reg, tvalid_next;
   logic             tuser_reg, tuser_next;
   logic             tlast_reg, tlast_next;
   logic             frame_done_reg, frame_done_next;
   logic [PIX_W-1:0] tdata_reg, tdata_next, pixel_next;
   logic [15:0]      frame_cnt_reg, frame_cnt_next;

   // Reset asserts immediately, but its release is aligned to ACLK.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) rst_sync_reg <= '0;
      else          rst_sync_reg <= {rst_sync_reg[0], 1'b1};
   end
   assign rst_n = rst_sync_reg[1];

   assign xfer = tvalid_reg & m_axis_tready;

   always_ff @(posedge ACLK or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         x_reg          <= '0;
         y_reg          <= '0;
         blank_reg      <= '0;
         mode_reg       <= SOLID;
         solid_reg      <= '0;
         tvalid_reg     <= 1'b0;
         tdata_reg      <= '0;
         tuser_reg      <= 1'b0;
         tlast_reg      <= 1'b0;
         frame_done_reg <= 1'b0;
         frame_cnt_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         blank_reg      <= blank_next;
         mode_reg       <= mode_next;
         solid_reg      <= solid_next;
         tvalid_reg     <= tvalid_next;
         tdata_reg      <= tdata_next;
         tuser_reg      <= tuser_next;
         tlast_reg      <= tlast_next;
         frame_done_reg <= frame_done_next;
         frame_cnt_reg  <= frame_cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      x_next     = x_reg;
      y_next     = y_reg;
      blank_next = blank_reg;
      mode_next  = mode_reg;
      solid_next = solid_reg;
      frame_end  = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (enable) begin
               state_next = ACTIVE;
               mode_next  = vid_mode_t'(mode);
               solid_next = solid_color;
               x_next     = '0;
               y_next     = '0;
            end
         end
         ACTIVE: begin
            if (xfer) begin
               if (x_reg == X_W'(H_ACTIVE - 1)) begin
                  x_next     = '0;
                  blank_next = '0;
                  if (y_reg == Y_W'(V_ACTIVE - 1)) begin
                     y_next     = '0;
                     state_next = VBLANK;
                     frame_end  = 1'b1;
                  end else begin
                     y_next     = y_reg + Y_W'(1);
                     state_next = (H_BLANK == 0) ? ACTIVE : HBLANK;
                  end
               end else begin
                  x_next = x_reg + X_W'(1);
               end
            end
         end
         HBLANK: begin
            if (blank_reg == B_W'(H_BLANK - 1)) state_next = ACTIVE;
            else                                blank_next = blank_reg + B_W'(1);
         end
         VBLANK: begin
            if (blank_reg == B_W'(VB_LEN - 1)) begin
               blank_next = '0;
               if (enable) begin
                  state_next = ACTIVE;
                  mode_next  = vid_mode_t'(mode);
                  solid_next = solid_color;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               blank_next = blank_reg + B_W'(1);
            end
         end
      endcase
   end

   vid_pattern_calc #(
      .DATA_W   (DATA_W),
      .NUM_CH   (NUM_CH),
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .CHK_LOG2 (CHK_LOG2)
   ) u_pattern (
      .mode  (mode_next),
      .x     (x_next),
      .y     (y_next),
      .solid (solid_next),
      .pixel (pixel_next)
   );

   // Outputs are loaded from the next coordinates, so a stalled beat reloads itself.
   always_comb begin
      tvalid_next     = (state_next == ACTIVE);
      tuser_next      = tvalid_next && (x_next == '0) && (y_next == '0);
      tlast_next      = tvalid_next && (x_next == X_W'(H_ACTIVE - 1));
      tdata_next      = tvalid_next ? pixel_next : '0;
      frame_done_next = frame_end;
      frame_cnt_next  = frame_cnt_reg + 16'(frame_end);
   end

   assign m_axis_tvalid = tvalid_reg;
   assign m_axis_tdata  = tdata_reg;
   assign m_axis_tuser  = tuser_reg;
   assign m_axis_tlast  = tlast_reg;
   assign busy          = (state_reg != IDLE);
   assign frame_done    = frame_done_reg;
   assign frame_cnt     = frame_cnt_reg;

endmodule

// File: tb/tb_axis_vid_frame_gen.sv
// Self-checking bench for axis_vid_frame_gen on a 16x4 frame with randomized backpressure.
module tb_axis_vid_frame_gen;

   localparam int DATA_W   = 8;
   localparam int NUM_CH   = 3;
   localparam int H_ACTIVE = 16;
   localparam int V_ACTIVE = 4;
   localparam int H_BLANK  = 2;
   localparam int V_BLANK  = 3;
   localparam int CHK_LOG2 = 3;
   localparam int PIX_W    = DATA_W * NUM_CH;
   localparam int BEATS    = H_ACTIVE * V_ACTIVE;

   logic             ACLK = 1'b0;
   logic             ARESETN = 1'b0;
   logic             enable = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [PIX_W-1:0] solid_color = '0;
   logic             m_axis_tready = 1'b0;
   logic             m_axis_tvalid;
   logic [PIX_W-1:0] m_axis_tdata;
   logic             m_axis_tuser;
   logic             m_axis_tlast;
   logic             busy;
   logic             frame_done;
   logic [15:0]      frame_cnt;

   axis_vid_frame_gen #(
      .DATA_W(DATA_W), .NUM_CH(NUM_CH), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
      .H_BLANK(H_BLANK), .V_BLANK(V_BLANK), .CHK_LOG2(CHK_LOG2)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable), .mode(mode),
      .solid_color(solid_color), .m_axis_tready(m_axis_tready),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata),
      .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
   );

   always #5 ACLK = ~ACLK;

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_frames = 0;

   logic [PIX_W-1:0] got_data[$];
   logic             got_user[$];
   logic             got_last[$];
   int               got_cyc[$];
   int               fd_cycles[$];
   int               stall_err;
   bit               timed_out;

   // Reference pixel straight from the pattern rules.
   function automatic logic [PIX_W-1:0] ref_pixel(input int m, input int x, input int y,
                                                  input logic [PIX_W-1:0] s);
      logic [PIX_W-1:0] p;
      int bar;
      p = '0;
      case (m)
         0: p = s;
         1: for (int c = 0; c < NUM_CH; c++) p[c*DATA_W +: DATA_W] = DATA_W'(x % (1 << DATA_W));
         2: begin
            bar = x / (H_ACTIVE / 8);
            if (bar > 7) bar = 7;
            for (int c = 0; c < NUM_CH; c++)
               if (((bar >> (c % 3)) & 1) == 1) p[c*DATA_W +: DATA_W] = '1;
         end
         default: if ((((x >> CHK_LOG2) ^ (y >> CHK_LOG2)) & 1) == 1) p = '1;
      endcase
      return p;
   endfunction

   // Runs the stream until one cycle after frame_done, logging accepted beats.
   task automatic collect_frame(input int rdy_pct, input int disable_at,
                                input int mode_at, input logic [1:0] mode_new);
      int budget = 0;
      int since = 0;
      bit fd_seen = 0;
      bit prev_stall = 0;
      logic [PIX_W-1:0] pd = '0;
      logic pu = 1'b0;
      logic pl = 1'b0;
      got_data.delete(); got_user.delete(); got_last.delete(); got_cyc.delete();
      fd_cycles.delete();
      stall_err = 0;
      timed_out = 0;
      while (!(fd_seen && since >= 1)) begin
         @(posedge ACLK); #1;
         cyc++; budget++;
         if (budget > 2000) begin timed_out = 1; break; end
         if (fd_seen) since++;
         if (frame_done === 1'b1) begin fd_cycles.push_back(cyc); fd_seen = 1; end
         if (prev_stall && (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd ||
                            m_axis_tuser !== pu || m_axis_tlast !== pl))
            stall_err++;
         m_axis_tready = ($urandom_range(99) < rdy_pct);
         if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_user.push_back(m_axis_tuser);
            got_last.push_back(m_axis_tlast);
            got_cyc.push_back(cyc);
            if (got_data.size() == disable_at) enable = 1'b0;
            if (got_data.size() == mode_at) mode = mode_new;
         end
         prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
         pd = m_axis_tdata; pu = m_axis_tuser; pl = m_axis_tlast;
      end
   endtask

   task automatic test_reset();
      ARESETN = 1'b0;
      for (int i = 0; i < 4; i++) begin
         enable = 1'($urandom); mode = 2'($urandom); solid_color = PIX_W'($urandom);
         m_axis_tready = 1'($urandom);
         @(posedge ACLK); #1; cyc++;
         n_checks++;
         if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, busy, frame_done, frame_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cyc %0d: got valid=%b data=%h user=%b last=%b busy=%b done=%b cnt=%0d, expected all 0",
                     i, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, busy, frame_done, frame_cnt);
         end
      end
      enable = 1'b0;
      ARESETN = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge ACLK); #1; cyc++;
         n_checks++;
         if ({m_axis_tvalid, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_hold cyc %0d: got valid=%b busy=%b, expected 0 0", i, m_axis_tvalid, busy);
         end
      end
      $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_solid();
      logic [PIX_W-1:0] s = 24'h123456;
      int gap, exp_gap;
      mode = 2'd0; solid_color = s; enable = 1'b1;
      collect_frame(100, 1, -1, 2'd0);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL solid_count: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         n_checks++;
         if ({got_data[i], got_user[i], got_last[i]} !== {s, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1}) begin
            n_fail++;
            $display("FAIL solid_beat[%0d]: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                     i, got_data[i], got_user[i], got_last[i], s, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1);
         end
      end
      for (int i = 1; i < got_cyc.size(); i++) begin
         gap = got_cyc[i] - got_cyc[i-1] - 1;
         exp_gap = (i % H_ACTIVE == 0) ? H_BLANK : 0;
         n_checks++;
         if (gap != exp_gap) begin
            n_fail++;
            $display("FAIL solid_gap[%0d]: got %0d idle cycles, expected %0d", i, gap, exp_gap);
         end
      end
      n_checks++;
      if (fd_cycles.size() != 1 || got_cyc.size() == 0 || fd_cycles[0] != got_cyc[got_cyc.size()-1] + 1) begin
         n_fail++;
         $display("FAIL solid_frame_done: got %0d pulse cycles, expected one pulse right after last beat", fd_cycles.size());
      end
      n_checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL solid_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
      end
      $display("test_solid done: beats=%0d checks=%0d failures=%0d", got_data.size(), n_checks, n_fail);
   endtask

   task automatic test_ramp_backpressure();
      logic [PIX_W-1:0] e;
      mode = 2'd1; enable = 1'b1;
      collect_frame(50, 1, -1, 2'd0);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL ramp_count: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         e = ref_pixel(1, i % H_ACTIVE, i / H_ACTIVE, '0);
         n_checks++;
         if ({got_data[i], got_user[i], got_last[i]} !== {e, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1}) begin
            n_fail++;
            $display("FAIL ramp_beat[%0d]: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                     i, got_data[i], got_user[i], got_last[i], e, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1);
         end
      end
      n_checks++;
      if (stall_err != 0) begin
         n_fail++;
         $display("FAIL ramp_stall_hold: got %0d unstable stall cycles, expected 0", stall_err);
      end
      n_checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL ramp_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
      end
      $display("test_ramp_backpressure done: beats=%0d checks=%0d failures=%0d", got_data.size(), n_checks, n_fail);
   endtask

   task automatic test_bars();
      int xs[7] = '{0, 1, 2, 4, 6, 14, 15};
      logic [PIX_W-1:0] ev[7] = '{24'h000000, 24'h000000, 24'h0000FF, 24'h00FF00,
                                  24'h00FFFF, 24'hFFFFFF, 24'hFFFFFF};
      logic [PIX_W-1:0] e;
      mode = 2'd2; enable = 1'b1;
      collect_frame(100, 1, -1, 2'd0);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL bars_count: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      for (int k = 0; k < 7; k++) begin
         n_checks++;
         if (got_data.size() <= xs[k] || got_data[xs[k]] !== ev[k]) begin
            n_fail++;
            $display("FAIL bars_x%0d: got %h, expected %h", xs[k],
                     (got_data.size() > xs[k]) ? got_data[xs[k]] : 'x, ev[k]);
         end
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         e = ref_pixel(2, i % H_ACTIVE, i / H_ACTIVE, '0);
         n_checks++;
         if (got_data[i] !== e) begin
            n_fail++;
            $display("FAIL bars_beat[%0d]: got %h, expected %h", i, got_data[i], e);
         end
      end
      $display("test_bars done: beats=%0d checks=%0d failures=%0d", got_data.size(), n_checks, n_fail);
   endtask

   task automatic test_checker_midframe();
      logic [PIX_W-1:0] e;
      bit saw_valid = 0;
      mode = 2'd3; enable = 1'b1; solid_color = PIX_W'($urandom);
      collect_frame(100, 20, 5, 2'd0);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL checker_count: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      n_checks++;
      if (got_data.size() < 9 || got_data[0] !== 24'h000000 || got_data[8] !== 24'hFFFFFF) begin
         n_fail++;
         $display("FAIL checker_corners: got (0,0)=%h (8,0)=%h, expected 000000 ffffff",
                  (got_data.size() > 0) ? got_data[0] : 'x, (got_data.size() > 8) ? got_data[8] : 'x);
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         e = ref_pixel(3, i % H_ACTIVE, i / H_ACTIVE, '0);
         n_checks++;
         if ({got_data[i], got_user[i], got_last[i]} !== {e, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1}) begin
            n_fail++;
            $display("FAIL checker_beat[%0d]: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                     i, got_data[i], got_user[i], got_last[i], e, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1);
         end
      end
      m_axis_tready = 1'b1;
      for (int i = 0; i < V_BLANK + 4; i++) begin
         @(posedge ACLK); #1; cyc++;
         if (m_axis_tvalid === 1'b1) saw_valid = 1;
      end
      n_checks++;
      if (saw_valid || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL checker_stop: got restart=%b busy=%b, expected restart=0 busy=0", saw_valid, busy);
      end
      $display("test_checker_midframe done: beats=%0d checks=%0d failures=%0d", got_data.size(), n_checks, n_fail);
   endtask

   task automatic test_back_to_back();
      logic [PIX_W-1:0] e;
      int last_cyc1, gap;
      mode = 2'd1; enable = 1'b1;
      collect_frame(100, -1, 30, 2'd2);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL b2b_count1: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         e = ref_pixel(1, i % H_ACTIVE, i / H_ACTIVE, '0);
         n_checks++;
         if (got_data[i] !== e) begin
            n_fail++;
            $display("FAIL b2b_frame1[%0d]: got %h, expected %h", i, got_data[i], e);
         end
      end
      last_cyc1 = (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : 0;
      collect_frame(100, 1, -1, 2'd0);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL b2b_count2: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      gap = (got_cyc.size() > 0) ? got_cyc[0] - last_cyc1 - 1 : -1;
      n_checks++;
      if (gap != V_BLANK) begin
         n_fail++;
         $display("FAIL b2b_vblank: got %0d idle cycles between frames, expected %0d", gap, V_BLANK);
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         e = ref_pixel(2, i % H_ACTIVE, i / H_ACTIVE, '0);
         n_checks++;
         if ({got_data[i], got_user[i]} !== {e, i == 0}) begin
            n_fail++;
            $display("FAIL b2b_frame2[%0d]: got data=%h user=%b, expected data=%h user=%b",
                     i, got_data[i], got_user[i], e, i == 0);
         end
      end
      n_checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL b2b_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
      end
      $display("test_back_to_back done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   task automatic test_reset_midframe();
      int beats = 0;
      int budget = 0;
      logic [PIX_W-1:0] e;
      mode = 2'd1; enable = 1'b1; m_axis_tready = 1'b1;
      while (beats < 10 && budget < 1000) begin
         @(posedge ACLK); #1; cyc++; budget++;
         if (m_axis_tvalid === 1'b1) beats++;
      end
      n_checks++;
      if (beats != 10) begin
         n_fail++;
         $display("FAIL rstmid_reach: got %0d beats before reset, expected 10", beats);
      end
      enable = 1'b0;
      ARESETN = 1'b0;
      #1;
      exp_frames = 0;
      n_checks++;
      if ({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, busy, frame_done, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: got valid=%b data=%h user=%b last=%b busy=%b cnt=%0d, expected all 0",
                  m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, busy, frame_cnt);
      end
      @(posedge ACLK); #1; cyc++;
      @(posedge ACLK); #1; cyc++;
      ARESETN = 1'b1;
      repeat (4) begin @(posedge ACLK); #1; cyc++; end
      n_checks++;
      if ({m_axis_tvalid, busy, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_idle: got valid=%b busy=%b cnt=%0d, expected 0 0 0", m_axis_tvalid, busy, frame_cnt);
      end
      mode = 2'd1; enable = 1'b1;
      collect_frame(100, 1, -1, 2'd0);
      exp_frames++;
      n_checks++;
      if (timed_out !== 1'b0 || got_data.size() != BEATS) begin
         n_fail++;
         $display("FAIL rstmid_count: got %0d beats (timeout=%b), expected %0d", got_data.size(), timed_out, BEATS);
      end
      for (int i = 0; i < got_data.size() && i < BEATS; i++) begin
         e = ref_pixel(1, i % H_ACTIVE, i / H_ACTIVE, '0);
         n_checks++;
         if ({got_data[i], got_user[i], got_last[i]} !== {e, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1}) begin
            n_fail++;
            $display("FAIL rstmid_beat[%0d]: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                     i, got_data[i], got_user[i], got_last[i], e, i == 0, (i % H_ACTIVE) == H_ACTIVE - 1);
         end
      end
      n_checks++;
      if (frame_cnt !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL rstmid_frame_cnt: got %0d, expected %0d", frame_cnt, exp_frames);
      end
      $display("test_reset_midframe done: checks=%0d failures=%0d", n_checks, n_fail);
   endtask

   initial begin
      test_reset();
      test_solid();
      test_ramp_backpressure();
      test_bars();
      test_checker_midframe();
      test_back_to_back();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected the test sequence to finish");
      $fatal(1, "watchdog expired");
   end

endmodule
